// File: rtl/ysyx_22051013_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22051013_hazard_ctl
// Brief    : ID-stage hazard control for an in-order pipeline. It tracks
//            pending register writes and in-flight instructions, generates
//            issue/stall/flush, and raises a sticky retire-underflow or
//            stall-watchdog error.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22051013_hazard_ctl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYC    = 2,
    parameter int STALL_TMO    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        rs1_ena,
    input  logic [4:0]  rs1_addr,
    input  logic        rs2_ena,
    input  logic [4:0]  rs2_addr,
    input  logic        rd_ena,
    input  logic [4:0]  rd_addr,
    input  logic        redirect_i,
    input  logic        retire_i,
    input  logic        wb_ena,
    input  logic [4:0]  wb_addr,
    output logic        issue_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] busy_o,
    output logic [2:0]  inflight_o,
    output logic        err_o
);

    localparam logic [2:0] C_FLUSH_LOAD = 3'(FLUSH_CYC - 1);
    localparam logic [2:0] C_MAX_INFL   = 3'(MAX_INFLIGHT);
    localparam logic [7:0] C_STALL_TMO  = 8'(STALL_TMO);

    typedef enum logic [0:0] {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    logic [2:0]  r_flush_cnt;
    logic [31:0] r_busy;
    logic [2:0]  r_inflight;
    logic [7:0]  r_stall_cnt;
    logic        r_err;

    logic        w_full;
    logic        w_hazard;
    logic        w_flush;
    logic        w_issue;
    logic        w_stall;
    logic        w_underflow;
    logic        w_retire_cnt;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_busy_next;
    logic [2:0]  w_inflight_next;
    logic [7:0]  w_stall_next;
    logic        w_tmo;

    // A retire in the same cycle frees a slot, so a full window is not a hazard then.
    assign w_full   = (r_inflight == C_MAX_INFL) & ~retire_i;
    assign w_hazard = (rs1_ena & r_busy[rs1_addr])
                    | (rs2_ena & r_busy[rs2_addr])
                    | (rd_ena  & r_busy[rd_addr])
                    | w_full;

    assign w_flush = ~rst & ((r_state == S_FLUSH) | redirect_i);
    assign w_issue = ~rst & id_valid & ~w_hazard & ~w_flush;
    assign w_stall = ~rst & id_valid &  w_hazard & ~w_flush;

    assign w_underflow  = retire_i & (r_inflight == 3'd0) & ~w_issue;
    assign w_retire_cnt = retire_i & ~w_underflow;

    assign w_set = (w_issue & rd_ena & (rd_addr != 5'd0)) ? (32'd1 << rd_addr) : 32'd0;
    assign w_clr = (retire_i & wb_ena) ? (32'd1 << wb_addr) : 32'd0;
    // Clear first, then set, so a same-index set wins; bit 0 is never tracked.
    assign w_busy_next = ((r_busy & ~w_clr) | w_set) & ~32'd1;

    always_comb begin
        w_inflight_next = r_inflight;
        case ({w_issue, w_retire_cnt})
            2'b10:   w_inflight_next = r_inflight + 3'd1;
            2'b01:   w_inflight_next = r_inflight - 3'd1;
            default: w_inflight_next = r_inflight;
        endcase
    end

    assign w_stall_next = w_stall ? ((r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1)
                                  : 8'd0;
    assign w_tmo        = w_stall & (w_stall_next >= C_STALL_TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_cnt <= 3'd0;
            r_busy      <= 32'd0;
            r_inflight  <= 3'd0;
            r_stall_cnt <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_busy      <= w_busy_next;
            r_inflight  <= w_inflight_next;
            r_stall_cnt <= w_stall_next;
            if (w_underflow | w_tmo) begin
                r_err <= 1'b1;
            end
            case (r_state)
                S_RUN: begin
                    if (redirect_i) begin
                        r_state     <= S_FLUSH;
                        r_flush_cnt <= C_FLUSH_LOAD;
                    end
                end
                S_FLUSH: begin
                    if (redirect_i) begin
                        r_flush_cnt <= C_FLUSH_LOAD;
                    end else if (r_flush_cnt == 3'd0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state     <= S_RUN;
                    r_flush_cnt <= 3'd0;
                end
            endcase
        end
    end

    assign issue_o    = w_issue;
    assign stall_o    = w_stall;
    assign flush_o    = w_flush;
    assign busy_o     = r_busy;
    assign inflight_o = r_inflight;
    assign err_o      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22051013_hazard_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22051013_hazard_ctl
// Brief    : Directed vector table plus randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22051013_hazard_ctl;

    localparam int MAXI = 4;
    localparam int FCYC = 2;
    localparam int TMO  = 3;

    logic        clk = 1'b0;
    logic        rst, id_valid, rs1_ena, rs2_ena, rd_ena, redirect_i, retire_i, wb_ena;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr, wb_addr;
    logic        issue_o, stall_o, flush_o, err_o;
    logic [31:0] busy_o;
    logic [2:0]  inflight_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_22051013_hazard_ctl #(
        .MAX_INFLIGHT(MAXI),
        .FLUSH_CYC   (FCYC),
        .STALL_TMO   (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .id_valid  (id_valid),
        .rs1_ena   (rs1_ena),
        .rs1_addr  (rs1_addr),
        .rs2_ena   (rs2_ena),
        .rs2_addr  (rs2_addr),
        .rd_ena    (rd_ena),
        .rd_addr   (rd_addr),
        .redirect_i(redirect_i),
        .retire_i  (retire_i),
        .wb_ena    (wb_ena),
        .wb_addr   (wb_addr),
        .issue_o   (issue_o),
        .stall_o   (stall_o),
        .flush_o   (flush_o),
        .busy_o    (busy_o),
        .inflight_o(inflight_o),
        .err_o     (err_o)
    );

    typedef struct {
        logic        rst, idv, r1e;
        logic [4:0]  r1;
        logic        r2e;
        logic [4:0]  r2;
        logic        rde;
        logic [4:0]  rd;
        logic        rdr, ret, wbe;
        logic [4:0]  wb;
        logic        ei, es, ef;
        logic [31:0] eb;
        logic [2:0]  en;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic a_rst, input logic a_idv,
                       input logic a_r1e, input logic [4:0] a_r1,
                       input logic a_r2e, input logic [4:0] a_r2,
                       input logic a_rde, input logic [4:0] a_rd,
                       input logic a_rdr, input logic a_ret,
                       input logic a_wbe, input logic [4:0] a_wb,
                       input logic a_ei, input logic a_es, input logic a_ef,
                       input logic [31:0] a_eb, input logic [2:0] a_en, input logic a_ee);
        vec_t v;
        v.rst = a_rst; v.idv = a_idv; v.r1e = a_r1e; v.r1 = a_r1;
        v.r2e = a_r2e; v.r2 = a_r2; v.rde = a_rde; v.rd = a_rd;
        v.rdr = a_rdr; v.ret = a_ret; v.wbe = a_wbe; v.wb = a_wb;
        v.ei = a_ei; v.es = a_es; v.ef = a_ef; v.eb = a_eb; v.en = a_en; v.ee = a_ee;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic a_rst, input logic a_idv,
                         input logic a_r1e, input logic [4:0] a_r1,
                         input logic a_r2e, input logic [4:0] a_r2,
                         input logic a_rde, input logic [4:0] a_rd,
                         input logic a_rdr, input logic a_ret,
                         input logic a_wbe, input logic [4:0] a_wb);
        rst = a_rst; id_valid = a_idv; rs1_ena = a_r1e; rs1_addr = a_r1;
        rs2_ena = a_r2e; rs2_addr = a_r2; rd_ena = a_rde; rd_addr = a_rd;
        redirect_i = a_rdr; retire_i = a_ret; wb_ena = a_wbe; wb_addr = a_wb;
    endtask

    // Reference model: register pending set, window occupancy, flush cycles left.
    logic [31:0] m_busy;
    int          m_infl, m_left, m_scnt;
    logic        m_err;
    logic        x_issue, x_stall, x_flush;

    task automatic model_eval();
        logic haz;
        haz = (rs1_ena && m_busy[rs1_addr]) || (rs2_ena && m_busy[rs2_addr]) ||
              (rd_ena && m_busy[rd_addr]) || (m_infl == MAXI && !retire_i);
        x_flush = !rst && (redirect_i || m_left > 0);
        x_issue = !rst && id_valid && !haz && !x_flush;
        x_stall = !rst && id_valid && haz && !x_flush;
    endtask

    task automatic model_step();
        if (rst) begin
            m_busy = 0; m_infl = 0; m_left = 0; m_scnt = 0; m_err = 0;
        end else begin
            if (retire_i && wb_ena) m_busy[wb_addr] = 1'b0;
            if (x_issue && rd_ena && rd_addr != 0) m_busy[rd_addr] = 1'b1;
            if (retire_i && m_infl == 0 && !x_issue) m_err = 1;
            else m_infl = m_infl + (x_issue ? 1 : 0) - (retire_i ? 1 : 0);
            if (x_stall) begin
                if (m_scnt < 255) m_scnt++;
                if (m_scnt >= TMO) m_err = 1;
            end else begin
                m_scnt = 0;
            end
            if (redirect_i) m_left = FCYC;
            else if (m_left > 0) m_left--;
        end
    endtask

    localparam logic [31:0] B5 = 32'h1 << 5;
    localparam logic [31:0] B7 = 32'h1 << 7;
    localparam logic [31:0] B9 = 32'h1 << 9;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // reset wins over live inputs
        add(1,1, 0,0, 0,0, 1,3, 1, 0,0,0,  0,0,0, 0,0,0);
        // RAW / WAW on x5, retire clears, issue follows
        add(0,1, 0,0, 0,0, 1,5, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,1, 0,0, 1,5, 0,0, 0, 0,0,0,  0,1,0, B5,1,0);
        add(0,1, 0,0, 0,0, 1,5, 0, 0,0,0,  0,1,0, B5,1,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, B5,1,0);
        add(0,1, 1,5, 0,0, 0,0, 0, 0,0,0,  0,1,0, B5,1,0);
        add(0,1, 1,5, 0,0, 0,0, 0, 1,1,5,  0,1,0, B5,1,0);
        add(0,1, 1,5, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 1,0,0,  0,0,0, 0,1,0);
        // x0 is never tracked
        add(0,1, 0,0, 0,0, 1,0, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,1, 1,0, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,1,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 1,0,0,  0,0,0, 0,2,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 1,0,0,  0,0,0, 0,1,0);
        // set beats clear on the same index
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,1, 0,0, 0,0, 1,7, 0, 1,1,7,  1,0,0, 0,1,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, B7,1,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 1,1,7,  0,0,0, B7,1,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,0,0);
        // retire underflow -> sticky error, cleared only by reset
        add(0,0, 0,0, 0,0, 0,0, 0, 1,0,0,  0,0,0, 0,0,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,0,1);
        add(1,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,0,1);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,0,0);
        // redirect at T and T+1 -> flush through T+3
        add(0,1, 0,0, 0,0, 1,1, 1, 0,0,0,  0,0,1, 0,0,0);
        add(0,1, 0,0, 0,0, 1,1, 1, 0,0,0,  0,0,1, 0,0,0);
        add(0,1, 0,0, 0,0, 1,1, 0, 0,0,0,  0,0,1, 0,0,0);
        add(0,1, 0,0, 0,0, 1,1, 0, 0,0,0,  0,0,1, 0,0,0);
        add(0,1, 0,0, 0,0, 1,0, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 1,0,0,  0,0,0, 0,1,0);
        // fill the window, stall, then retire-and-issue
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,1,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,2,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,3,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  0,1,0, 0,4,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 1,0,0,  1,0,0, 0,4,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,4,0);
        // three held stalls trip the watchdog
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  0,1,0, 0,4,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  0,1,0, 0,4,0);
        add(0,1, 0,0, 0,0, 0,0, 0, 0,0,0,  0,1,0, 0,4,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,4,1);
        add(1,1, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,4,1);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,0,0);
        // reset mid-flush with a write pending discards everything
        add(0,1, 0,0, 0,0, 1,9, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,1, 0,0, 0,0, 0,0, 1, 0,0,0,  0,0,1, B9,1,0);
        add(1,1, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, B9,1,0);
        add(0,1, 1,9, 0,0, 0,0, 0, 0,0,0,  1,0,0, 0,0,0);
        add(0,0, 0,0, 0,0, 0,0, 0, 0,0,0,  0,0,0, 0,1,0);

        foreach (tbl[i]) begin
            vec_t v;
            v = tbl[i];
            drive(v.rst, v.idv, v.r1e, v.r1, v.r2e, v.r2, v.rde, v.rd, v.rdr, v.ret, v.wbe, v.wb);
            @(negedge clk);
            chk($sformatf("vec%0d issue", i),    32'(issue_o),    32'(v.ei));
            chk($sformatf("vec%0d stall", i),    32'(stall_o),    32'(v.es));
            chk($sformatf("vec%0d flush", i),    32'(flush_o),    32'(v.ef));
            chk($sformatf("vec%0d busy", i),     busy_o,          v.eb);
            chk($sformatf("vec%0d inflight", i), 32'(inflight_o), 32'(v.en));
            chk($sformatf("vec%0d err", i),      32'(err_o),      32'(v.ee));
            @(posedge clk);
            #1;
        end

        // randomized run against the model
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_eval();
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                  1'($urandom), 5'($urandom_range(0, 7)));
            model_eval();
            @(negedge clk);
            chk($sformatf("rnd%0d issue", c),    32'(issue_o),    32'(x_issue));
            chk($sformatf("rnd%0d stall", c),    32'(stall_o),    32'(x_stall));
            chk($sformatf("rnd%0d flush", c),    32'(flush_o),    32'(x_flush));
            chk($sformatf("rnd%0d busy", c),     busy_o,          m_busy);
            chk($sformatf("rnd%0d inflight", c), 32'(inflight_o), 32'(m_infl));
            chk($sformatf("rnd%0d err", c),      32'(err_o),      32'(m_err));
            model_step();
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
